// File: rtl/audio_pkg.sv
// Shared audio-path definitions: sample width, serializer state encoding and
// the bit-counter width used to index a sample.
package audio_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PAD
  } state_t;

endpackage

// File: rtl/lrclk_edge_det.sv
// Word-clock edge detector: one registered copy of LRCLK and single-cycle
// pulses marking the start of a left (falling) or right (rising) word.
module lrclk_edge_det (
  input  logic clk,
  input  logic i_rst,
  input  logic i_lrclk,
  output logic o_negedge,
  output logic o_posedge
);

  logic lrclk_d;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) lrclk_d <= 1'b0;
    else       lrclk_d <= i_lrclk;
  end

  // Gated by reset so no pulse escapes while the register is held clear.
  assign o_negedge = ~i_rst &  lrclk_d & ~i_lrclk;
  assign o_posedge = ~i_rst & ~lrclk_d &  i_lrclk;

endmodule

// File: rtl/i2s_dac_tx.sv
// I2S DAC transmitter: one-pair holding buffer, per-frame L/R latching on the
// left-word edge, and an MSB-first serializer aligned one BCLK after LRCLK.
module i2s_dac_tx #(
  parameter int unsigned DATA_W = audio_pkg::DATA_W,
  parameter int unsigned UCNT_W = 8
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_lrclk,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data_l,
  input  logic [DATA_W-1:0] i_data_r,
  output logic              o_ready,
  output logic              o_dacdat,
  output logic              o_lrclk_negedge,
  output logic              o_lrclk_posedge,
  output logic [UCNT_W-1:0] o_underflow_cnt
);

  import audio_pkg::*;

  localparam int unsigned BIT_W = $clog2(DATA_W);

  logic              neg, pos, accept;
  state_t            state, state_nx;
  logic [BIT_W-1:0]  bit_cnt, cnt_nx, idx;
  logic              chan_r, chan_nx;
  logic              buf_full;
  logic [DATA_W-1:0] buf_l, buf_r, frame_l, frame_r;
  logic [UCNT_W-1:0] ucnt;

  lrclk_edge_det u_edge (
    .clk       (clk),
    .i_rst     (i_rst),
    .i_lrclk   (i_lrclk),
    .o_negedge (neg),
    .o_posedge (pos)
  );

  assign o_lrclk_negedge = neg;
  assign o_lrclk_posedge = pos;
  assign o_underflow_cnt = ucnt;

  // Ready is held low in the left-edge cycle so a pair offered then is taken
  // only after the buffer has been handed to the frame registers.
  assign o_ready = ~i_rst & i_en & ~buf_full & ~neg;
  assign accept  = i_valid & o_ready;
  assign idx     = BIT_W'(DATA_W - 1) - bit_cnt;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      buf_full <= 1'b0;
      buf_l    <= '0;
      buf_r    <= '0;
      frame_l  <= '0;
      frame_r  <= '0;
      ucnt     <= '0;
    end else begin
      if (neg && !buf_full && ucnt != '1) ucnt <= ucnt + 1'b1;
      if (!i_en) begin
        buf_full <= 1'b0;
        frame_l  <= '0;
        frame_r  <= '0;
      end else if (neg) begin
        buf_full <= 1'b0;
        frame_l  <= buf_full ? buf_l : '0;
        frame_r  <= buf_full ? buf_r : '0;
      end else if (accept) begin
        buf_full <= 1'b1;
        buf_l    <= i_data_l;
        buf_r    <= i_data_r;
      end
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      chan_r  <= 1'b0;
    end else begin
      state   <= state_nx;
      bit_cnt <= cnt_nx;
      chan_r  <= chan_nx;
    end
  end

  // The MSB leaves in the pulse cycle itself, so it is taken from the source
  // register (buffer for left, frame for right) before the transfer lands.
  always_comb begin
    state_nx = state;
    cnt_nx   = bit_cnt;
    chan_nx  = chan_r;
    o_dacdat = 1'b0;
    if (!i_en) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end else if (neg) begin
      state_nx = SHIFT;
      chan_nx  = 1'b0;
      cnt_nx   = BIT_W'(1);
      o_dacdat = buf_full & buf_l[DATA_W-1];
    end else if (pos && state != IDLE) begin
      state_nx = SHIFT;
      chan_nx  = 1'b1;
      cnt_nx   = BIT_W'(1);
      o_dacdat = frame_r[DATA_W-1];
    end else if (state == SHIFT) begin
      o_dacdat = chan_r ? frame_r[idx] : frame_l[idx];
      if (bit_cnt == BIT_W'(DATA_W - 1)) begin
        state_nx = PAD;
        cnt_nx   = '0;
      end else begin
        cnt_nx = bit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Directed bench for i2s_dac_tx: cycle vector table for edge/handshake timing,
// then frame-level sequences for alignment, underflow, truncation, reset, enable.
module tb_i2s_dac_tx;

  logic        clk = 1'b0;
  logic        rst, en, lr, valid;
  logic [15:0] dl, dr;
  logic        ready, dat, negp, posp;
  logic [7:0]  ucnt;

  always #5 clk = ~clk;

  i2s_dac_tx #(.DATA_W(16), .UCNT_W(8)) dut (
    .clk             (clk),
    .i_rst           (rst),
    .i_en            (en),
    .i_lrclk         (lr),
    .i_valid         (valid),
    .i_data_l        (dl),
    .i_data_r        (dr),
    .o_ready         (ready),
    .o_dacdat        (dat),
    .o_lrclk_negedge (negp),
    .o_lrclk_posedge (posp),
    .o_underflow_cnt (ucnt)
  );

  typedef struct {
    logic        lr;
    logic        valid;
    logic [15:0] l;
    logic [15:0] r;
    logic        e_ready;
    logic        e_neg;
    logic        e_pos;
    logic        e_dat;
  } vec_t;

  vec_t tab[11];

  int checks = 0;
  int failures = 0;
  logic       s_ready, s_dat, s_neg, s_pos;
  logic [7:0] s_ucnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    #2;
    s_ready = ready;
    s_dat   = dat;
    s_neg   = negp;
    s_pos   = posp;
    s_ucnt  = ucnt;
    @(posedge clk);
    #1;
  endtask

  task automatic run_half(input logic level, input int n, output logic [31:0] bits);
    logic [31:0] acc;
    acc = '0;
    lr  = level;
    for (int i = 0; i < n; i++) begin
      tick();
      acc = {acc[30:0], s_dat};
    end
    bits = acc;
  endtask

  logic [31:0] b;
  int          acc_cnt;
  logic        dat_or, rdy_or;

  initial begin
    tab[0]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    tab[1]  = '{1'b1, 1'b1, 16'h8001, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b0};
    tab[2]  = '{1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
    tab[3]  = '{1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1};
    tab[4]  = '{1'b0, 1'b1, 16'h4000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
    tab[5]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
    tab[6]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1};
    tab[7]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1};
    tab[8]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
    tab[9]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1};
    tab[10] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; en = 1'b1; lr = 1'b1; valid = 1'b0; dl = '0; dr = '0;
    #2;
    check("rst_ready", ready, 0);
    check("rst_dat",   dat,   0);
    check("rst_neg",   negp,  0);
    check("rst_pos",   posp,  0);
    check("rst_ucnt",  ucnt,  0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Cycle vectors: edge pulses, handshake and first-bit alignment
    for (int i = 0; i < 11; i++) begin
      lr = tab[i].lr; valid = tab[i].valid; dl = tab[i].l; dr = tab[i].r;
      tick();
      check($sformatf("vec%0d_ready", i), s_ready, tab[i].e_ready);
      check($sformatf("vec%0d_neg", i),   s_neg,   tab[i].e_neg);
      check($sformatf("vec%0d_pos", i),   s_pos,   tab[i].e_pos);
      check($sformatf("vec%0d_dat", i),   s_dat,   tab[i].e_dat);
    end
    valid = 1'b0;
    check("vec_ucnt", s_ucnt, 0);

    // Scenario 1: 32-BCLK frame with 8001/7FFE
    rst = 1'b1; tick(); rst = 1'b0;
    run_half(1'b1, 4, b);
    check("idle_after_rst", b[3:0], 4'h0);
    dl = 16'h8001; dr = 16'h7FFE; valid = 1'b1;
    tick();
    check("s1_accept", s_ready, 1);
    valid = 1'b0;
    run_half(1'b0, 16, b);
    check("s1_left", b[15:0], 16'h8001);
    run_half(1'b1, 16, b);
    check("s1_right", b[15:0], 16'h7FFE);

    // Scenario 2: underflow frames and counter saturation
    run_half(1'b0, 16, b); check("s2_left0", b[15:0], 16'h0000);
    run_half(1'b1, 16, b); check("s2_right0", b[15:0], 16'h0000);
    run_half(1'b0, 16, b); check("s2_left1", b[15:0], 16'h0000);
    run_half(1'b1, 16, b);
    check("s2_ucnt2", s_ucnt, 2);
    for (int i = 0; i < 300; i++) begin
      run_half(1'b0, 1, b);
      run_half(1'b1, 1, b);
    end
    check("s2_ucnt_sat", s_ucnt, 255);

    // Scenario 3: 12-BCLK halves truncate the word
    dl = 16'hFFFF; dr = 16'hA5A5; valid = 1'b1;
    tick();
    valid = 1'b0;
    run_half(1'b0, 12, b); check("s3_left12", b[11:0], 12'hFFF);
    run_half(1'b1, 4, b);  check("s3_right_msb", b[3:0], 4'hA);
    run_half(1'b1, 8, b);  check("s3_right_rest", b[7:0], 8'h5A);

    // Scenario 4: valid held high, one acceptance per frame
    dl = 16'hFFC3; dr = 16'h0000; valid = 1'b1;
    for (int f = 0; f < 3; f++) begin
      acc_cnt = 0;
      b = '0;
      for (int i = 0; i < 32; i++) begin
        lr = (i < 16) ? 1'b0 : 1'b1;
        tick();
        if (s_ready) acc_cnt++;
        if (i < 16) b = {b[30:0], s_dat};
        if (i == 0) check($sformatf("s4_f%0d_ready_neg", f), s_ready, 0);
        if (i == 1) check($sformatf("s4_f%0d_ready_next", f), s_ready, 1);
      end
      check($sformatf("s4_f%0d_accepts", f), acc_cnt, 1);
      if (f > 0) check($sformatf("s4_f%0d_left", f), b[15:0], 16'hFFC3);
    end
    valid = 1'b0;

    // Scenario 5: reset at bit 7 of a left word
    run_half(1'b0, 7, b);
    check("s5_first7", b[6:0], 7'h7F);
    rst = 1'b1;
    tick();
    check("s5_rst_dat", s_dat, 0);
    check("s5_rst_ready", s_ready, 0);
    rst = 1'b0;
    dl = 16'h9999; dr = 16'h1111; valid = 1'b1;
    tick();
    check("s5_accept", s_ready, 1);
    valid = 1'b0;
    run_half(1'b0, 7, b);  check("s5_rest_low", b[6:0], 7'h00);
    run_half(1'b1, 16, b); check("s5_no_right", b[15:0], 16'h0000);
    run_half(1'b0, 16, b); check("s5_new_left", b[15:0], 16'h9999);
    run_half(1'b1, 16, b); check("s5_new_right", b[15:0], 16'h1111);

    // Scenario 6: enable dropped mid-word, raised during a right half
    dl = 16'h1357; dr = 16'h2468; valid = 1'b1;
    tick();
    valid = 1'b0;
    run_half(1'b0, 5, b);
    check("s6_first5", b[4:0], 5'h02);
    en = 1'b0; valid = 1'b1; dat_or = 1'b0; rdy_or = 1'b0;
    for (int i = 0; i < 43; i++) begin
      lr = (i < 11) ? 1'b0 : ((i < 27) ? 1'b1 : 1'b0);
      tick();
      dat_or = dat_or | s_dat;
      rdy_or = rdy_or | s_ready;
    end
    check("s6_dat_off", dat_or, 0);
    check("s6_ready_off", rdy_or, 0);
    check("s6_ucnt_en_low", s_ucnt, 1);
    en = 1'b1; lr = 1'b1; dl = 16'hACE1; dr = 16'h0000;
    tick();
    check("s6_ready_on", s_ready, 1);
    check("s6_pos_idle_dat", s_dat, 0);
    valid = 1'b0;
    run_half(1'b1, 15, b); check("s6_idle_high", b[14:0], 15'h0000);
    run_half(1'b0, 16, b); check("s6_left", b[15:0], 16'hACE1);
    check("s6_ucnt_final", s_ucnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
